// File: rtl/sample_loader_pkg.sv
// Shared definitions for the ADC frame loader: frame geometry, the complex
// RAM word layout, the loader state encoding and the sample conversion helper.
package sample_loader_pkg;

  localparam int N_LOG2    = 12;
  localparam int FRAME_LEN = 1 << N_LOG2;
  localparam int SAMPLE_W  = 12;

  localparam logic [N_LOG2-1:0] LAST_INDEX = '1;

  // One transform input word: {re, im}, both Q1.15.
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_START,
    S_WAIT_DONE
  } loader_state_t;

  // Offset binary to two's complement is an MSB flip; left-justify into Q1.15.
  function automatic cplx_t to_cplx(input logic [SAMPLE_W-1:0] s);
    cplx_t c;
    c.re = {~s[SAMPLE_W-1], s[SAMPLE_W-2:0], {(16-SAMPLE_W){1'b0}}};
    c.im = '0;
    return c;
  endfunction

endpackage

// File: rtl/sample_loader_if.sv
// Sample stream, engine handshake and RAM write port of the frame loader.
// slave = the loader itself, master = whatever drives samples / observes RAM.
interface sample_loader_if;
  import sample_loader_pkg::*;

  logic                run;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                fft_done;
  logic                sample_ready;
  logic                ram_we;
  logic [N_LOG2-1:0]   ram_addr;
  logic [31:0]         ram_data;
  logic                ram_owner;
  logic                start;
  logic [15:0]         drop_count;

  modport slave (
    input  run, sample_valid, sample, fft_done,
    output sample_ready, ram_we, ram_addr, ram_data, ram_owner, start, drop_count
  );

  modport master (
    output run, sample_valid, sample, fft_done,
    input  sample_ready, ram_we, ram_addr, ram_data, ram_owner, start, drop_count
  );

endinterface

// File: rtl/sample_loader_bit_reverse.sv
// Combinational bit reversal of a W-bit index, used for DIT-ordered frame
// addressing. Only built when SAMPLE_LOADER_BITREV_EN is defined.
`ifdef SAMPLE_LOADER_BITREV_EN
module bit_reverse #(
  parameter int W = 12
) (
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_rev
      assign o_data[gi] = i_data[W-1-gi];
    end
  endgenerate

endmodule
`endif

// File: rtl/sample_loader.sv
// Frame loader: converts offset-binary ADC samples to complex Q1.15 words,
// fills one 2^N_LOG2-point frame into the transform input RAM, pulses start,
// then waits for a rising edge of fft_done before taking the next frame.
// Optional macro SAMPLE_LOADER_BITREV_EN: write addresses are bit-reversed.
module sample_loader
  import sample_loader_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  sample_loader_if.slave bus
);

  loader_state_t     r_state;
  loader_state_t     w_state_next;
  logic [N_LOG2-1:0] r_index;
  logic [N_LOG2-1:0] w_addr;
  logic              r_done_prev;
  logic              r_ram_we;
  logic [N_LOG2-1:0] r_ram_addr;
  cplx_t             r_ram_data;
  logic              r_start;
  logic [15:0]       r_drop_count;

  logic w_ready;
  logic w_accept;
  logic w_write;
  logic w_done_rise;
  logic w_drop;

  assign w_ready     = (r_state == S_FILL);
  assign w_accept    = bus.sample_valid & w_ready;
  // A sample taken in the same cycle run falls belongs to a discarded frame.
  assign w_write     = w_accept & bus.run;
  assign w_done_rise = bus.fft_done & ~r_done_prev;
  assign w_drop      = bus.sample_valid & ~w_ready & bus.run & (r_drop_count != 16'hFFFF);

`ifdef SAMPLE_LOADER_BITREV_EN
  bit_reverse #(.W(N_LOG2)) u_bit_reverse (
    .i_data (r_index),
    .o_data (w_addr)
  );
`else
  assign w_addr = r_index;
`endif

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.run) w_state_next = S_FILL;
      end
      S_FILL: begin
        if (!bus.run)                                 w_state_next = S_IDLE;
        else if (w_write && (r_index == LAST_INDEX))  w_state_next = S_START;
      end
      S_START: begin
        w_state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (w_done_rise) w_state_next = bus.run ? S_FILL : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Frame index: zero outside FILL so every fill starts at point 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  r_index <= '0;
    else if (r_state != S_FILL) r_index <= '0;
    else if (w_write)           r_index <= r_index + {{(N_LOG2-1){1'b0}}, 1'b1};
  end

  // Previous fft_done, so a level already high on WAIT_DONE entry is not an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_done_prev <= 1'b0;
    else       r_done_prev <= bus.fft_done;
  end

  // Registered RAM write port: one cycle after each accepted sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
    end else begin
      r_ram_we <= w_write;
      if (w_write) begin
        r_ram_addr <= w_addr;
        r_ram_data <= to_cplx(bus.sample);
      end
    end
  end

  // Start pulse follows the START state, landing one cycle after the last write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_start <= 1'b0;
    else       r_start <= (r_state == S_START);
  end

  // Saturating count of samples offered while the loader cannot take them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_drop_count <= '0;
    else if (w_drop) r_drop_count <= r_drop_count + 16'd1;
  end

  assign bus.sample_ready = w_ready;
  assign bus.ram_we       = r_ram_we;
  assign bus.ram_addr     = r_ram_addr;
  assign bus.ram_data     = r_ram_data;
  // Keep the port while filling and through the final registered write.
  assign bus.ram_owner    = w_ready | r_ram_we;
  assign bus.start        = r_start;
  assign bus.drop_count   = r_drop_count;

endmodule

// File: tb/tb_sample_loader.sv
// Directed self-checking bench for sample_loader.
module tb_sample_loader;
  import sample_loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sample_loader_if bus();

  sample_loader dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // Transaction record filled by a passive monitor on the falling edge.
  logic [11:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          overlap_cnt = 0;
  int          frame_base = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ram_we) begin
        wr_addr_q.push_back(bus.ram_addr);
        wr_data_q.push_back(bus.ram_data);
        wr_cyc_q.push_back(cyc);
      end
      if (bus.start) begin
        start_cnt = start_cnt + 1;
        start_cyc = cyc;
        if (bus.ram_we) overlap_cnt = overlap_cnt + 1;
      end
    end
  end

  function automatic logic [11:0] exp_addr(input int k);
    logic [11:0] r;
    r = '0;
`ifdef SAMPLE_LOADER_BITREV_EN
    for (int b = 0; b < 12; b++) r[b] = k[11-b];
`else
    r = k[11:0];
`endif
    return r;
  endfunction

  function automatic logic [31:0] exp_data(input int k);
    logic [11:0] s;
    s = k[11:0];
    return {s ^ 12'h800, 4'h0, 16'h0000};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bus.run = 1'b0; bus.sample_valid = 1'b0; bus.sample = '0; bus.fft_done = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.sample_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.sample_ready); end
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.ram_we); end
    checks++; if (bus.ram_addr !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", bus.ram_addr); end
    checks++; if (bus.ram_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.ram_data); end
    checks++; if (bus.ram_owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b want 0", bus.ram_owner); end
    checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", bus.start); end
    checks++; if (bus.drop_count !== 16'h0) begin errors++; $display("FAIL reset_drop: got %h want 0", bus.drop_count); end
    rst = 1'b0;
    tick();
    checks++; if (bus.sample_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b want 0", bus.sample_ready); end
    $display("test_reset: done");
  endtask

  task automatic test_full_frame;
    int s0;
    int n;
    int bad;
    s0 = start_cnt;
    frame_base = wr_addr_q.size();
    bus.fft_done = 1'b1;   // already high when WAIT_DONE is entered
    bus.run = 1'b1;
    tick();
    checks++; if (bus.sample_ready !== 1'b1) begin errors++; $display("FAIL fill_ready: got %b want 1", bus.sample_ready); end
    checks++; if (bus.ram_owner !== 1'b1) begin errors++; $display("FAIL fill_owner: got %b want 1", bus.ram_owner); end
    for (int i = 0; i < 4096; i++) begin
      bus.sample = i[11:0];
      bus.sample_valid = 1'b1;
      tick();
    end
    bus.sample_valid = 1'b0;
    checks++; if ({bus.ram_we, bus.ram_owner, bus.start} !== 3'b110) begin errors++; $display("FAIL last_write: got we/owner/start %b want 110", {bus.ram_we, bus.ram_owner, bus.start}); end
    tick();
    checks++; if ({bus.ram_we, bus.ram_owner, bus.start} !== 3'b001) begin errors++; $display("FAIL start_cycle: got we/owner/start %b want 001", {bus.ram_we, bus.ram_owner, bus.start}); end
    repeat (3) tick();
    n = wr_addr_q.size() - frame_base;
    checks++; if (n !== 4096) begin errors++; $display("FAIL frame_writes: got %0d want 4096", n); end
    if (n > 4096) n = 4096;
    bad = 0;
    for (int k = 0; k < n; k++) if (wr_addr_q[frame_base+k] !== exp_addr(k)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL frame_addr: got %0d bad addresses want 0", bad); end
    bad = 0;
    for (int k = 0; k < n; k++) if (wr_data_q[frame_base+k] !== exp_data(k)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL frame_data: got %0d bad words want 0", bad); end
    if (n == 4096) begin
      checks++; if (wr_cyc_q[frame_base+4095] - wr_cyc_q[frame_base] !== 4095) begin errors++; $display("FAIL frame_span: got %0d cycles want 4095", wr_cyc_q[frame_base+4095] - wr_cyc_q[frame_base]); end
      checks++; if (start_cyc - wr_cyc_q[frame_base+4095] !== 1) begin errors++; $display("FAIL start_delay: got %0d want 1", start_cyc - wr_cyc_q[frame_base+4095]); end
    end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL start_count: got %0d want 1", start_cnt - s0); end
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL start_we_overlap: got %0d want 0", overlap_cnt); end
    checks++; if (bus.drop_count !== 16'd0) begin errors++; $display("FAIL frame_drops: got %0d want 0", bus.drop_count); end
    $display("test_full_frame: %0d writes", n);
  endtask

  task automatic test_conversion;
    logic [11:0] a1;
`ifdef SAMPLE_LOADER_BITREV_EN
    a1 = 12'h800;
`else
    a1 = 12'h001;
`endif
    checks++; if (wr_data_q[frame_base+2048] !== 32'h00000000) begin errors++; $display("FAIL conv_800: got %h want 00000000", wr_data_q[frame_base+2048]); end
    checks++; if (wr_data_q[frame_base+4095] !== 32'h7FF00000) begin errors++; $display("FAIL conv_FFF: got %h want 7FF00000", wr_data_q[frame_base+4095]); end
    checks++; if (wr_data_q[frame_base] !== 32'h80000000) begin errors++; $display("FAIL conv_000: got %h want 80000000", wr_data_q[frame_base]); end
    checks++; if (wr_addr_q[frame_base+1] !== a1) begin errors++; $display("FAIL addr_index1: got %h want %h", wr_addr_q[frame_base+1], a1); end
    $display("test_conversion: done");
  endtask

  task automatic test_drop_count;
    int w0;
    w0 = wr_addr_q.size();
    bus.sample = 12'h555;
    bus.sample_valid = 1'b1;
    repeat (20) tick();
    bus.sample_valid = 1'b0;
    tick();
    checks++; if (bus.drop_count !== 16'd20) begin errors++; $display("FAIL drop_20: got %0d want 20", bus.drop_count); end
    checks++; if (wr_addr_q.size() - w0 !== 0) begin errors++; $display("FAIL drop_writes: got %0d want 0", wr_addr_q.size() - w0); end
    $display("test_drop_count: done");
  endtask

  task automatic test_drop_saturate;
    bus.sample_valid = 1'b1;
    repeat (65600) tick();
    bus.sample_valid = 1'b0;
    tick();
    checks++; if (bus.drop_count !== 16'hFFFF) begin errors++; $display("FAIL drop_sat: got %h want FFFF", bus.drop_count); end
    $display("test_drop_saturate: done");
  endtask

  task automatic test_fft_done_edge;
    int s0;
    s0 = start_cnt;
    repeat (5) tick();
    checks++; if (bus.sample_ready !== 1'b0) begin errors++; $display("FAIL done_held: got ready %b want 0", bus.sample_ready); end
    bus.fft_done = 1'b0;
    repeat (2) tick();
    checks++; if (bus.sample_ready !== 1'b0) begin errors++; $display("FAIL done_low: got ready %b want 0", bus.sample_ready); end
    bus.fft_done = 1'b1;
    tick();
    checks++; if (bus.sample_ready !== 1'b1) begin errors++; $display("FAIL done_rise: got ready %b want 1", bus.sample_ready); end
    tick();
    checks++; if (bus.sample_ready !== 1'b1 || start_cnt !== s0) begin errors++; $display("FAIL done_refill: got ready %b starts %0d want 1 and %0d", bus.sample_ready, start_cnt, s0); end
    $display("test_fft_done_edge: done");
  endtask

  task automatic test_run_drop;
    int w0;
    int s0;
    w0 = wr_addr_q.size();
    s0 = start_cnt;
    for (int i = 0; i < 100; i++) begin
      bus.sample = i[11:0];
      bus.sample_valid = 1'b1;
      tick();
    end
    bus.sample_valid = 1'b0;
    bus.run = 1'b0;
    tick();
    checks++; if (bus.sample_ready !== 1'b0) begin errors++; $display("FAIL rundrop_ready: got %b want 0", bus.sample_ready); end
    repeat (3) tick();
    checks++; if (start_cnt !== s0) begin errors++; $display("FAIL rundrop_start: got %0d want %0d", start_cnt, s0); end
    checks++; if (wr_addr_q.size() - w0 !== 100) begin errors++; $display("FAIL rundrop_writes: got %0d want 100", wr_addr_q.size() - w0); end
    bus.run = 1'b1;
    tick();
    bus.sample = 12'h123;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== exp_addr(0)) begin errors++; $display("FAIL rerun_addr: got we %b addr %h want 1 %h", bus.ram_we, bus.ram_addr, exp_addr(0)); end
    checks++; if (bus.ram_data !== 32'h92300000) begin errors++; $display("FAIL rerun_data: got %h want 92300000", bus.ram_data); end
    $display("test_run_drop: done");
  endtask

  task automatic test_async_reset;
    int w0;
    int s0;
    s0 = start_cnt;
    bus.sample = 12'hABC;
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    checks++; if (bus.ram_we !== 1'b1 || bus.ram_addr !== exp_addr(1) || bus.ram_data !== 32'h2BC00000) begin errors++; $display("FAIL pre_reset_write: got %b %h %h want 1 %h 2bc00000", bus.ram_we, bus.ram_addr, bus.ram_data, exp_addr(1)); end
    #2;
    rst = 1'b1;
    #1;
    w0 = wr_addr_q.size();
    checks++; if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL arst_we: got %b want 0", bus.ram_we); end
    checks++; if (bus.sample_ready !== 1'b0) begin errors++; $display("FAIL arst_ready: got %b want 0", bus.sample_ready); end
    checks++; if (bus.ram_owner !== 1'b0) begin errors++; $display("FAIL arst_owner: got %b want 0", bus.ram_owner); end
    checks++; if (bus.ram_addr !== 12'h000 || bus.ram_data !== 32'h0) begin errors++; $display("FAIL arst_addr_data: got %h %h want 000 00000000", bus.ram_addr, bus.ram_data); end
    checks++; if (bus.start !== 1'b0) begin errors++; $display("FAIL arst_start: got %b want 0", bus.start); end
    checks++; if (bus.drop_count !== 16'h0) begin errors++; $display("FAIL arst_drop: got %h want 0", bus.drop_count); end
    @(posedge clk);
    #3;
    bus.run = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (bus.sample_ready !== 1'b0 || bus.ram_we !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got ready %b we %b want 0 0", bus.sample_ready, bus.ram_we); end
    checks++; if (wr_addr_q.size() !== w0 || start_cnt !== s0) begin errors++; $display("FAIL post_reset_quiet: got writes %0d starts %0d want %0d %0d", wr_addr_q.size(), start_cnt, w0, s0); end
    $display("test_async_reset: done");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_conversion();
    test_drop_count();
    test_drop_saturate();
    test_fft_done_edge();
    test_run_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
